// File: rtl/obuf_a_data_if.sv
// Downstream link handshake between an output buffer and the next router's input buffer.
interface obuf_a_data_if #(
  parameter int unsigned PYLD_W = 17
);
  logic              link_vld;
  logic              link_rdy;
  logic [PYLD_W-1:0] link_payload;

  modport master (output link_vld, output link_payload, input link_rdy);
  modport slave  (input link_vld, input link_payload, output link_rdy);
endinterface

// File: rtl/obuf_a_data.sv
// Per-output-port buffer: captures the granted input-buffer payload into a small FIFO
// and presents the head entry downstream with a valid/ready handshake.
module obuf_a_data #(
  parameter int unsigned PYLD_W = 17,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pg_en,
  input  logic [4:0]            arb_gnt,
  input  logic [5*PYLD_W-1:0]   payload_i,
  output logic                  obuf_rdy,
  obuf_a_data_if.master         link,
  output logic [3:0]            occupancy,
  output logic                  gnt_err
);

  localparam int unsigned N_IN  = 5;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PYLD_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [3:0]        r_occ;
  logic              r_gnt_err;

  logic              w_nonzero;
  logic              w_onehot;
  logic              w_multi;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [PYLD_W-1:0] w_sel;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_nonzero = (arb_gnt != 5'd0);
  assign w_onehot  = w_nonzero && ((arb_gnt & (arb_gnt - 5'd1)) == 5'd0);
  assign w_multi   = w_nonzero && !w_onehot;
  assign w_full    = (r_occ == 4'(DEPTH));
  assign w_empty   = (r_occ == 4'd0);

  // Ready is a function of registered state and pg_en only, so no loop through the arbiter.
  assign obuf_rdy  = !rst && !pg_en && !w_full;
  assign w_push    = obuf_rdy && w_onehot;
  assign w_pop     = !w_empty && link.link_rdy;

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < int'(N_IN); i++) begin
      if (arb_gnt[i]) w_sel = w_sel | payload_i[i*PYLD_W +: PYLD_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_occ     <= 4'd0;
      r_gnt_err <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else begin
      if (w_multi) r_gnt_err <= 1'b1;
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_sel;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 4'd1;
        2'b01:   r_occ <= r_occ - 4'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign link.link_vld     = !w_empty;
  assign link.link_payload = r_mem[r_rd_ptr];
  assign occupancy         = r_occ;
  assign gnt_err           = r_gnt_err;

endmodule

// File: tb/tb_obuf_a_data.sv
// Directed bench for obuf_a_data with a queue scoreboard drained by a link monitor.
module tb_obuf_a_data;
  localparam int unsigned PYLD_W = 17;

  logic               clk = 1'b0;
  logic               rst;
  logic               pg_en;
  logic [4:0]         arb_gnt;
  logic [5*PYLD_W-1:0] payload_i;
  logic               obuf_rdy;
  logic [3:0]         occupancy;
  logic               gnt_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [PYLD_W-1:0] sb [$];

  obuf_a_data_if #(.PYLD_W(PYLD_W)) lnk ();

  obuf_a_data #(.PYLD_W(PYLD_W), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .pg_en     (pg_en),
    .arb_gnt   (arb_gnt),
    .payload_i (payload_i),
    .obuf_rdy  (obuf_rdy),
    .link      (lnk),
    .occupancy (occupancy),
    .gnt_err   (gnt_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Unselected slices carry distinct junk so a wrong mux selection is visible.
  task automatic drive(input logic [4:0] g, input int idx, input logic [PYLD_W-1:0] d);
    for (int i = 0; i < 5; i++) payload_i[i*PYLD_W +: PYLD_W] = PYLD_W'(17'h0F0F0 + i);
    payload_i[idx*PYLD_W +: PYLD_W] = d;
    arb_gnt = g;
  endtask

  task automatic grant(input int idx, input logic [PYLD_W-1:0] d, input bit exp_push);
    drive(5'(1 << idx), idx, d);
    #1;
    check("obuf_rdy_at_grant", 32'(obuf_rdy), 32'(exp_push));
    if (exp_push) sb.push_back(d);
  endtask

  // Monitor: compares the head entry on every handshake, and checks stability while stalled.
  always @(negedge clk) begin
    if (!rst && lnk.link_vld) begin
      if (sb.size() == 0) begin
        check("unexpected_link_vld", 32'(lnk.link_vld), 32'd0);
      end else if (lnk.link_rdy) begin
        check("link_payload_pop", 32'(lnk.link_payload), 32'(sb[0]));
        void'(sb.pop_front());
      end else begin
        check("link_payload_hold", 32'(lnk.link_payload), 32'(sb[0]));
      end
    end
  end

  initial begin
    rst = 1'b1; pg_en = 1'b0; arb_gnt = 5'd0; payload_i = '0; lnk.link_rdy = 1'b1;
    tick();
    check("rdy_during_rst", 32'(obuf_rdy), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("rst_vld", 32'(lnk.link_vld), 32'd0);
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_payload", 32'(lnk.link_payload), 32'd0);
    check("rst_gnt_err", 32'(gnt_err), 32'd0);
    check("rst_rdy", 32'(obuf_rdy), 32'd1);

    // Single push, one-cycle latency, immediate drain.
    grant(2, 17'h1ABCD, 1'b1);
    tick();
    arb_gnt = 5'd0;
    check("t1_vld", 32'(lnk.link_vld), 32'd1);
    check("t1_payload", 32'(lnk.link_payload), 32'h1ABCD);
    tick();
    check("t1_vld_after", 32'(lnk.link_vld), 32'd0);
    check("t1_occ_after", 32'(occupancy), 32'd0);

    // Fill with downstream stalled; third grant refused.
    lnk.link_rdy = 1'b0;
    grant(0, 17'h00011, 1'b1); tick();
    grant(1, 17'h00022, 1'b1); tick();
    check("t2_occ_full", 32'(occupancy), 32'd2);
    grant(2, 17'h00033, 1'b0); tick();
    arb_gnt = 5'd0;
    check("t2_occ_hold", 32'(occupancy), 32'd2);
    lnk.link_rdy = 1'b1;
    tick();
    check("t2_occ_pop1", 32'(occupancy), 32'd1);
    check("t2_rdy_pop1", 32'(obuf_rdy), 32'd1);
    tick();
    check("t2_occ_pop2", 32'(occupancy), 32'd0);

    // Streaming at one entry: simultaneous push/pop across pointer wraps.
    lnk.link_rdy = 1'b0;
    grant(0, 17'h00100, 1'b1); tick();
    lnk.link_rdy = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      grant(k % 5, PYLD_W'(17'h00100 + k), 1'b1);
      tick();
      check("t3_occ_stream", 32'(occupancy), 32'd1);
    end
    arb_gnt = 5'd0;
    tick();
    check("t3_occ_end", 32'(occupancy), 32'd0);

    // Multi-hot grant: ignored and sticky error.
    lnk.link_rdy = 1'b0;
    grant(0, 17'h00155, 1'b1); tick();
    drive(5'b00110, 1, 17'h0DEAD); tick();
    check("t4_occ_multi", 32'(occupancy), 32'd1);
    check("t4_gnt_err", 32'(gnt_err), 32'd1);
    grant(0, 17'h00156, 1'b1); tick();
    arb_gnt = 5'd0;
    check("t4_gnt_err_sticky", 32'(gnt_err), 32'd1);
    check("t4_occ_two", 32'(occupancy), 32'd2);
    lnk.link_rdy = 1'b1;
    tick(); tick();
    check("t4_drained", 32'(occupancy), 32'd0);
    rst = 1'b1; tick(); rst = 1'b0; #1;
    check("t4_gnt_err_clr", 32'(gnt_err), 32'd0);

    // Power-gate: refuse pushes, keep draining, ready returns with pg_en low.
    lnk.link_rdy = 1'b0;
    grant(3, 17'h00AAA, 1'b1); tick();
    grant(1, 17'h01555, 1'b1); tick();
    pg_en = 1'b1; lnk.link_rdy = 1'b1;
    grant(4, 17'h1FFFF, 1'b0);
    tick();
    check("t5_occ1", 32'(occupancy), 32'd1);
    tick();
    check("t5_occ0", 32'(occupancy), 32'd0);
    check("t5_vld0", 32'(lnk.link_vld), 32'd0);
    check("t5_rdy_gated", 32'(obuf_rdy), 32'd0);
    arb_gnt = 5'd0;
    pg_en = 1'b0;
    #1;
    check("t5_rdy_ungated", 32'(obuf_rdy), 32'd1);

    // Reset with entries queued and downstream stalled.
    lnk.link_rdy = 1'b0;
    grant(0, 17'h00077, 1'b1); tick();
    grant(4, 17'h00088, 1'b1); tick();
    arb_gnt = 5'd0;
    check("t6_occ_pre", 32'(occupancy), 32'd2);
    rst = 1'b1;
    sb.delete();
    tick();
    check("t6_vld", 32'(lnk.link_vld), 32'd0);
    check("t6_occ", 32'(occupancy), 32'd0);
    check("t6_payload", 32'(lnk.link_payload), 32'd0);
    check("t6_rdy_in_rst", 32'(obuf_rdy), 32'd0);
    rst = 1'b0;
    #1;
    check("t6_rdy_after", 32'(obuf_rdy), 32'd1);

    tick();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
